ddr3_app_responder: RTL

//  Responder side of the DDR3 controller user (app_*) interface: a cycle-accurate memory model that accepts

---
 rtl/ddr3_app_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_app_responder.sv
// Cycle-accurate stand-in for the DDR3 controller user interface: calibration delay,
// write-data FIFO, command back-pressure, byte-masked storage and fixed-latency reads.
module ddr3_app_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 28,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int ADDR_SHIFT     = 3,
    parameter int RD_LATENCY     = 4,
    parameter int CALIB_CYCLES   = 16,
    parameter int WDF_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_rdy,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int PTR_W  = $clog2(WDF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PEND_WR = 1'b1
    } cmd_state_e;

    cmd_state_e                state_q, state_d;
    logic [MEM_DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;

    logic             calib_q;
    logic [CAL_W-1:0] cal_cnt_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [WDF_DEPTH];
    logic [NBYTES-1:0]     fifo_mask_q [WDF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];

    logic [ADDR_WIDTH-1:0]     word_addr_s;
    logic [MEM_DEPTH_LOG2-1:0] word_idx_s;
    logic                      fifo_empty_s, fifo_full_s;
    logic                      beat_s, cmd_acc_s, wr_cmd_s, rd_cmd_s;
    logic                      commit_s, push_s, pop_s;
    logic [MEM_DEPTH_LOG2-1:0] commit_idx_s;
    logic [DATA_WIDTH-1:0]     commit_data_s;
    logic [NBYTES-1:0]         commit_mask_s;
    logic                      unused_s;

    // Upper address bits wrap; app_wdf_end always mirrors app_wdf_wren for single beats.
    assign word_addr_s = app_addr >> ADDR_SHIFT;
    assign word_idx_s  = word_addr_s[MEM_DEPTH_LOG2-1:0];
    assign unused_s    = ^{word_addr_s[ADDR_WIDTH-1:MEM_DEPTH_LOG2], app_wdf_end};

    assign fifo_empty_s = (fifo_cnt_q == CNT_W'(0));
    assign fifo_full_s  = (fifo_cnt_q == CNT_W'(WDF_DEPTH));

    assign app_rdy     = calib_q & (state_q == ST_IDLE);
    assign app_wdf_rdy = calib_q & ~fifo_full_s;

    assign beat_s    = app_wdf_wren & app_wdf_rdy;
    assign cmd_acc_s = app_en & app_rdy;
    assign wr_cmd_s  = cmd_acc_s & (app_cmd == 3'b000);
    assign rd_cmd_s  = cmd_acc_s & (app_cmd == 3'b001);

    // Command FSM: decides when a write commits and which index it targets.
    always_comb begin
        state_d      = state_q;
        pend_idx_d   = pend_idx_q;
        commit_s     = 1'b0;
        commit_idx_s = word_idx_s;
        case (state_q)
            ST_IDLE: begin
                if (wr_cmd_s) begin
                    if (!fifo_empty_s || beat_s) begin
                        commit_s = 1'b1;
                    end else begin
                        state_d    = ST_PEND_WR;
                        pend_idx_d = word_idx_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND_WR: begin
                commit_idx_s = pend_idx_q;
                if (!fifo_empty_s || beat_s) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_PEND_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // An empty FIFO lets the same-cycle beat bypass straight into storage.
    assign pop_s         = commit_s & ~fifo_empty_s;
    assign push_s        = beat_s & ~(commit_s & fifo_empty_s);
    assign commit_data_s = fifo_empty_s ? app_wdf_data : fifo_data_q[rd_ptr_q];
    assign commit_mask_s = fifo_empty_s ? app_wdf_mask : fifo_mask_q[rd_ptr_q];

    // FSM state and pending-write index register.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    // Calibration counter; completion flag is sticky until the next reset.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            calib_q   <= 1'b0;
            cal_cnt_q <= '0;
        end else if (!calib_q) begin
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_q <= 1'b1;
            end
            cal_cnt_q <= cal_cnt_q + CAL_W'(1);
        end
    end

    // Write-data FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Write-data FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_q[wr_ptr_q] <= app_wdf_data;
            fifo_mask_q[wr_ptr_q] <= app_wdf_mask;
        end
    end

    // Byte-masked storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!commit_mask_s[b]) begin
                    mem_q[commit_idx_s][b*8 +: 8] <= commit_data_s[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures storage at acceptance, last stage drives the outputs.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_dat_q[i] <= '0;
            end
        end else begin
            rd_vld_q[0] <= rd_cmd_s;
            rd_dat_q[0] <= rd_cmd_s ? mem_q[word_idx_s] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dat_q[i] <= rd_dat_q[i-1];
            end
        end
    end

    assign app_rd_data         = rd_dat_q[RD_LATENCY-1];
    assign app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data_end     = rd_vld_q[RD_LATENCY-1];
    assign init_calib_complete = calib_q;

endmodule
